// File: rtl/tik_sched.sv
// tik_sched: timestep scheduler for the neuron work controller.
// Issues a TIK_HIGH-cycle tik pulse at the start of every timestep. Timesteps are
// period_l cycles long, where period_l = max(period, MIN_PERIOD) is latched at run start.
// A timestep ends at its deadline only if the work controller and the spike path are idle.
// If either is busy, the end of the step is deferred and an overrun is flagged.
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   sched_en            run request (level); dropping it mid-run ends the run after the current step
//   period, step_num    cycles per timestep; timesteps to run (0 = free-run)
//   work_busy, spk_busy downstream busy indications, checked at the deadline
//   tik                 timestep pulse
//   step_cnt            completed timesteps this run (saturating)
//   overrun             one-cycle pulse when a deadline is missed
//   overrun_cnt         missed deadlines this run (saturating at 255)
//   sched_busy          scheduler not idle
//   sched_done          one-cycle pulse at the end of a run
//
// state | meaning
// IDLE  | waiting for sched_en
// TIK   | tik high, counting the TIK_HIGH pulse
// RUN   | tik low, counting up to the deadline
// WAIT  | deadline missed, waiting for both busy inputs to clear
// DONE  | run finished, sched_done high for one cycle
module tik_sched #(
  parameter int TW         = 16,
  parameter int STW        = 16,
  parameter int TIK_HIGH   = 4,
  parameter int MIN_PERIOD = TIK_HIGH + 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sched_en,
  input  logic [TW-1:0]  period,
  input  logic [STW-1:0] step_num,
  input  logic           work_busy,
  input  logic           spk_busy,
  output logic           tik,
  output logic [STW-1:0] step_cnt,
  output logic           overrun,
  output logic [7:0]     overrun_cnt,
  output logic           sched_busy,
  output logic           sched_done
);

  typedef enum logic [2:0] {IDLE, TIK, RUN, WAIT, DONE} state_t;

  localparam logic [TW-1:0]  MIN_P    = TW'(MIN_PERIOD);
  localparam logic [TW-1:0]  TIK_LAST = TW'(TIK_HIGH - 1);
  localparam logic [STW-1:0] STEP_MAX = '1;

  state_t         state, state_nx;
  logic [TW-1:0]  pc, pc_nx;
  logic [TW-1:0]  period_l, period_nx;
  logic [STW-1:0] step_num_l, step_num_nx;
  logic [STW-1:0] step_cnt_nx;
  logic [7:0]     ovr_cnt_nx;
  logic           stop_req, stop_nx;
  logic           overrun_nx;
  logic           step_end;
  logic           any_busy;

  assign any_busy   = work_busy | spk_busy;
  assign sched_busy = (state != IDLE);

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    period_nx   = period_l;
    step_num_nx = step_num_l;
    step_cnt_nx = step_cnt;
    ovr_cnt_nx  = overrun_cnt;
    stop_nx     = stop_req;
    overrun_nx  = 1'b0;
    step_end    = 1'b0;

    case (state)
      IDLE: begin
        if (sched_en) begin
          state_nx    = TIK;
          period_nx   = (period < MIN_P) ? MIN_P : period;
          step_num_nx = step_num;
          step_cnt_nx = '0;
          ovr_cnt_nx  = '0;
          pc_nx       = '0;
          stop_nx     = 1'b0;
        end
      end
      TIK: begin
        pc_nx = pc + TW'(1);
        if (pc == TIK_LAST) state_nx = RUN;
      end
      RUN: begin
        if (pc == period_l - TW'(1)) begin
          if (any_busy) begin
            // pc is left at the deadline value while waiting
            state_nx   = WAIT;
            overrun_nx = 1'b1;
            if (overrun_cnt != 8'hFF) ovr_cnt_nx = overrun_cnt + 8'd1;
          end else begin
            step_end = 1'b1;
          end
        end else begin
          pc_nx = pc + TW'(1);
        end
      end
      WAIT: begin
        if (!any_busy) step_end = 1'b1;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (step_end) begin
      pc_nx = '0;
      if (step_cnt != STEP_MAX) step_cnt_nx = step_cnt + STW'(1);
      // compares the count before this step's increment
      if (stop_req || (step_num_l != '0 && step_cnt + STW'(1) == step_num_l))
        state_nx = DONE;
      else
        state_nx = TIK;
    end

    if ((state == TIK || state == RUN || state == WAIT) && !sched_en) stop_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      period_l    <= '0;
      step_num_l  <= '0;
      stop_req    <= 1'b0;
      tik         <= 1'b0;
      step_cnt    <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
      sched_done  <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      period_l    <= period_nx;
      step_num_l  <= step_num_nx;
      stop_req    <= stop_nx;
      tik         <= (state_nx == TIK);
      step_cnt    <= step_cnt_nx;
      overrun     <= overrun_nx;
      overrun_cnt <= ovr_cnt_nx;
      sched_done  <= (state_nx == DONE);
    end
  end

endmodule

// File: doc/tik_sched.md
TIK_SCHED -- requirements
Module: tik_sched

Interface
REQ-001 Parameter TW, default 16, period counter and period input width.
REQ-002 Parameter STW, default 16, timestep count width.
REQ-003 Parameter TIK_HIGH, default 4, tik pulse high time in cycles (>=1).
REQ-004 Parameter MIN_PERIOD, default TIK_HIGH+4, smallest effective period in cycles.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 sched_en  input  1  level; run request from the configurator.
REQ-008 period  input  TW  cycles per timestep.
REQ-009 step_num  input  STW  timesteps to run; 0 = free-run.
REQ-010 work_busy  input  1  neuron work controller not idle.
REQ-011 spk_busy  input  1  spike output path holds undelivered spikes.
REQ-012 tik  output  1  timestep pulse; the work controller triggers on its falling edge.
REQ-013 step_cnt  output  STW  completed timesteps since run start.
REQ-014 overrun  output  1  one-cycle pulse when a timestep deadline is missed.
REQ-015 overrun_cnt  output  8  saturating count of overruns since run start.
REQ-016 sched_busy  output  1  high whenever state != IDLE.
REQ-017 sched_done  output  1  one-cycle pulse at run end.

Function
REQ-018 FSM states are IDLE, TIK, RUN, WAIT, DONE; all outputs are registered except sched_busy, which decodes the state register.
REQ-019 IDLE->TIK when sched_en=1. On this transition: latch period_l = max(period, MIN_PERIOD) and step_num_l; clear step_cnt, overrun_cnt, the period counter pc, and stop_req.
REQ-020 TIK: tik=1. pc increments by 1 each cycle, starting at 0 on TIK entry.
REQ-021 TIK->RUN when pc==TIK_HIGH-1. The tik high time is exactly TIK_HIGH cycles.
REQ-022 RUN: tik=0, and pc keeps incrementing.
REQ-023 Deadline: the deadline is the cycle in which pc==period_l-1 in RUN.
REQ-024 Deadline with work_busy=0 and spk_busy=0: take the step-end action (REQ-026).
REQ-025 Deadline with either busy input high: go to WAIT, pulse overrun for 1 cycle, and increment overrun_cnt, saturating at 255.
REQ-026 WAIT exits via the step-end action in the first cycle in which both busy inputs are 0. pc holds its value in WAIT.
REQ-027 Step-end action: step_cnt increments by 1, saturating at all-ones, and pc is cleared.
REQ-028 After the step-end action: if stop_req=1, or if step_num_l!=0 and step_cnt+1==step_num_l, go to DONE. Otherwise go to TIK.
REQ-029 DONE: sched_done=1 for exactly 1 cycle, then unconditionally go to IDLE. step_cnt and overrun_cnt hold their values until the next run start.
REQ-030 sched_en=0 in any state other than IDLE or DONE sets stop_req. The current timestep completes, and no further tik is issued.
REQ-031 sched_en re-asserted after stop_req is set does not clear stop_req. A new run starts only from IDLE.
REQ-032 period, step_num and sched_en changes other than those above have no effect mid-run, because only the latched values are used.
REQ-033 Minimum tik spacing: consecutive tik rising edges are at least period_l cycles apart, and exactly period_l cycles apart when no overrun occurs.
REQ-034 step_num_l==1: exactly one tik pulse is issued, then the FSM goes to DONE.
REQ-035 Free-run (step_num_l==0) continues until stop_req is set. step_cnt saturates and does not wrap.

Reset
REQ-036 On rst_n=0, asynchronously and regardless of state: state=IDLE; tik=0, step_cnt=0, overrun=0, overrun_cnt=0, sched_done=0; pc=0, stop_req=0, period_l=0, step_num_l=0.
REQ-037 Reset mid-pulse drops tik immediately, and no sched_done is produced.
REQ-038 After rst_n rises, the first run needs sched_en=1 sampled in IDLE.

Verification
REQ-039 period=20, step_num=3, busies 0, sched_en held 1 -> three 4-cycle tik pulses with rising edges 20 cycles apart; step_cnt=3; sched_done 1 cycle after the third deadline; sched_busy=0 afterwards.
REQ-040 period=3 (below MIN_PERIOD=8), step_num=2 -> tik rising edges 8 cycles apart; step_cnt=2.
REQ-041 period=20, step_num=2, work_busy held high from cycle 5 to cycle 30 of step 1 -> overrun pulse at the deadline; overrun_cnt=1; the second tik rises 1 cycle after work_busy falls; step_cnt=2.
REQ-042 Free-run with period=16; deassert sched_en during the RUN phase of step 5 -> step 5 completes; step_cnt=5; sched_done pulses; no sixth tik.
REQ-043 Assert rst_n=0 during a tik pulse -> tik=0 immediately; all outputs return to their reset values; no sched_done.
REQ-044 Change period and step_num mid-run -> tik spacing and run length follow the values latched at run start.
